rtc_bus_driver: RTL and testbench
=================================

# rtc_bus_driver

Physical bus engine for the real-time clock. It sits directly downstream of the PicoBlaze RTC port controller: it consumes that controller's write/read requests (`actesc`/`actlec`) with the latched register address and data, and runs one multiplexed address/data bus cycle on the RTC pins. It then returns `esclisto`/`memorialisto` and the read byte `datomem`.

## Interface
- `T_PULSE`, 8: clk cycles per strobe pulse (address or data phase); legal 1..255
- `T_GAP`, 4: clk cycles of idle/turnaround after each pulse; legal 1..255
- `CMD_ADDR`, 8'hF1: RTC transfer-command address, used only with `RTC_TRANSFER_CMD_EN`
- `clk` in 1: system clock; the only clock
- `reset` in 1: synchronous, active-high reset
- `actesc` in 1: write request level, held high by the controller until `esclisto` is seen
- `actlec` in 1: read request level, same handshake with `memorialisto`
- `dir` in 8: RTC register address
- `dato` in 8: write data
- `ad_in` in 8: RTC AD bus sampled value
- `esclisto` out 1: write complete
- `memorialisto` out 1: read complete
- `datomem` out 8: last read byte
- `ad_out` out 8: AD bus drive value
- `ad_oe` out 1: AD bus output enable; the top-level tristate is driven by this
- `cs_n`, `rd_n`, `wr_n` out 1: active-low RTC strobes
- `a_d` out 1: 1 = address phase, 0 = data phase

## Operation
- Reset values: `esclisto` = 0, `memorialisto` = 0, `datomem` = 0, `ad_out` = 0, `ad_oe` = 0, `cs_n` = 1, `rd_n` = 1, `wr_n` = 1, `a_d` = 0. State is IDLE.
- States: IDLE, ADDR, AGAP, DATA, DGAP, DONE. With `RTC_TRANSFER_CMD_EN`, CADDR, CAGAP, CDATA and CDGAP are added.
- IDLE:
  - On `actesc`, latch `dir`/`dato` and set op = write, then go to ADDR.
  - Otherwise, on `actlec`, latch `dir` and set op = read, then go to ADDR.
  - If both are high, write has priority.
- ADDR, T_PULSE cycles: `cs_n` = 0, `wr_n` = 0, `a_d` = 1, `ad_out` = latched address, `ad_oe` = 1.
- AGAP, T_GAP cycles: all strobes high and `a_d` = 0. `ad_out` is held and `ad_oe` = 1, which gives address hold.
- DATA, T_PULSE cycles:
  - Write: `cs_n` = 0, `wr_n` = 0, `ad_out` = latched data, `ad_oe` = 1.
  - Read: `cs_n` = 0, `rd_n` = 0, `ad_oe` = 0. `ad_in` is registered into `datomem` on the last DATA cycle.
- DGAP, T_GAP cycles: strobes high. For a write, `ad_oe` stays 1 and `ad_out` is held. For a read, `ad_oe` = 0.
- DONE: `esclisto` (write) or `memorialisto` (read) is held at 1 until the corresponding request drops. The flag clears and the state returns to IDLE on the cycle after the drop.
- Requests arriving outside IDLE are ignored. Latched `dir`/`dato` changes mid-cycle have no effect.
- `datomem` holds its value until the next read completes; writes never alter it.
- `reset` mid-cycle: on the next edge all strobes go high, `ad_oe` goes to 0, flags clear, and the state goes to IDLE. `datomem` clears.
- Phase counter: 8-bit down-counter loaded with `T_PULSE-1` or `T_GAP-1` on phase entry. The phase ends when the counter reaches 0. No wrap is possible.

## Timing
- Cycle 0 is the edge where IDLE samples the request. ADDR occupies cycles 1..T_PULSE.
- With defaults, `esclisto`/`memorialisto` first read 1 at cycle 2*(T_PULSE+T_GAP)+1, which is 25.
- With `RTC_TRANSFER_CMD_EN` on a write, completion is at cycle 4*(T_PULSE+T_GAP)+1, which is 49.
- Read data is valid in `datomem` from cycle T_PULSE*2+T_GAP+1, before `memorialisto` rises.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `RTC_TRANSFER_CMD_EN` defined:
  - After DGAP of a write, the block runs a second full write cycle (CADDR/CAGAP/CDATA/CDGAP) to `CMD_ADDR` with data `CMD_ADDR`. This commits the RTC buffer to the timekeeper.
  - DONE follows that second cycle.
  - Reads are unchanged.
- Undefined: writes end after a single cycle, and the four extra states are absent.

## Structure
- Package `rtc_bus_pkg` holds the state encoding, the `T_PULSE`/`T_GAP` defaults, and `CMD_ADDR`.
- Sub-module `rtc_phase_timer` is a loadable 8-bit down-counter with a `zero` flag. The FSM loads it on each phase entry.

## Test plan
- Write `dir` = 8'h22, `dato` = 8'h59, `actesc` held → `wr_n`/`cs_n` low for 8 cycles with `ad_out` = 8'h22 and `a_d` = 1, then 4 gap cycles, then 8 cycles with `ad_out` = 8'h59. `esclisto` = 1 at cycle 25 and clears 1 cycle after `actesc` drops.
- Read `dir` = 8'h41 with `ad_in` = 8'h17 during DATA → `rd_n` low for 8 cycles with `ad_oe` = 0, `datomem` = 8'h17, `memorialisto` = 1 at cycle 25. A following write leaves `datomem` = 8'h17.
- `actesc` and `actlec` rise on the same cycle → a write cycle runs, `rd_n` stays 1 throughout, and `memorialisto` stays 0.
- Assert `reset` at cycle 12 of a write → at cycle 13 all strobes = 1, `ad_oe` = 0, state IDLE, and no `esclisto`.
- With `RTC_TRANSFER_CMD_EN` defined, a write to 8'h23 → a second cycle with `ad_out` = 8'hF1 in both address and data phases, and `esclisto` at cycle 49.
- `T_PULSE` = 1, `T_GAP` = 1 → write completes at cycle 5, with 1-cycle strobes.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared state encoding and timing defaults for the RTC bus engine.
// Optional feature macro: RTC_TRANSFER_CMD_EN (adds the commit-command cycle).
package rtc_bus_pkg;

  localparam int unsigned T_PULSE_DEF = 8;
  localparam int unsigned T_GAP_DEF = 4;
  localparam logic [7:0] CMD_ADDR_DEF = 8'hF1;

`ifdef RTC_TRANSFER_CMD_EN
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_AGAP, S_DATA, S_DGAP, S_DONE,
    S_CADDR, S_CAGAP, S_CDATA, S_CDGAP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_AGAP, S_DATA, S_DGAP, S_DONE
  } state_t;
`endif

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_t;

endpackage

// File: rtl/rtc_bus_driver_if.sv
// rtc_bus_driver_if: controller request/response and RTC pin bundle.
// slave is the bus engine side, master is the controller/pad side.
interface rtc_bus_driver_if;

  logic       actesc;
  logic       actlec;
  logic [7:0] dir;
  logic [7:0] dato;
  logic [7:0] ad_in;
  logic       esclisto;
  logic       memorialisto;
  logic [7:0] datomem;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d;

  modport slave (
    input  actesc, actlec, dir, dato, ad_in,
    output esclisto, memorialisto, datomem,
    output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
  );

  modport master (
    output actesc, actlec, dir, dato, ad_in,
    input  esclisto, memorialisto, datomem,
    input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
  );

endinterface

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: loadable 8-bit down-counter timing each bus phase.
// zero marks the final cycle of the phase that loaded it.
module rtc_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] cnt_q;

  // load on phase entry, otherwise count down and stop at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != 8'd0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/rtc_bus_driver.sv
// rtc_bus_driver: multiplexed address/data RTC bus cycle engine.
// Macro RTC_TRANSFER_CMD_EN appends a commit write to CMD_ADDR after each write.
module rtc_bus_driver
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_PULSE  = T_PULSE_DEF,
  parameter int unsigned T_GAP    = T_GAP_DEF,
  parameter logic [7:0]  CMD_ADDR = CMD_ADDR_DEF
) (
  input logic            clk,
  input logic            reset,
  rtc_bus_driver_if.slave bus
);

  localparam logic [7:0] PULSE_LD = 8'(T_PULSE - 1);
  localparam logic [7:0] GAP_LD   = 8'(T_GAP - 1);

  state_t     state_q, state_d;
  op_t        op_q;
  logic [7:0] addr_q, data_q;
  logic       ld;
  logic [7:0] ld_val;
  logic       zero;
  logic       rel;

  logic       esc_q, mem_q, last_q;
  logic       cs_q, rd_q, wr_q, ad_q, oe_q;
  logic [7:0] out_q, dm_q;

  rtc_phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (ld),
    .load_val (ld_val),
    .zero     (zero)
  );

  assign rel = (op_q == OP_WR) ? !bus.actesc : !bus.actlec;

  // state register plus request capture in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_WR;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) begin
        if (bus.actesc) begin
          op_q   <= OP_WR;
          addr_q <= bus.dir;
          data_q <= bus.dato;
        end else if (bus.actlec) begin
          op_q   <= OP_RD;
          addr_q <= bus.dir;
        end
      end
    end
  end

  // next state and phase-timer load on every phase entry
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    ld_val  = PULSE_LD;
    unique case (state_q)
      S_IDLE: begin
        if (bus.actesc || bus.actlec) begin
          state_d = S_ADDR;
          ld      = 1'b1;
        end
      end
      S_ADDR: begin
        if (zero) begin
          state_d = S_AGAP;
          ld      = 1'b1;
          ld_val  = GAP_LD;
        end
      end
      S_AGAP: begin
        if (zero) begin
          state_d = S_DATA;
          ld      = 1'b1;
        end
      end
      S_DATA: begin
        if (zero) begin
          state_d = S_DGAP;
          ld      = 1'b1;
          ld_val  = GAP_LD;
        end
      end
      S_DGAP: begin
        if (zero) begin
`ifdef RTC_TRANSFER_CMD_EN
          if (op_q == OP_WR) begin
            state_d = S_CADDR;
            ld      = 1'b1;
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef RTC_TRANSFER_CMD_EN
      S_CADDR: begin
        if (zero) begin
          state_d = S_CAGAP;
          ld      = 1'b1;
          ld_val  = GAP_LD;
        end
      end
      S_CAGAP: begin
        if (zero) begin
          state_d = S_CDATA;
          ld      = 1'b1;
        end
      end
      S_CDATA: begin
        if (zero) begin
          state_d = S_CDGAP;
          ld      = 1'b1;
          ld_val  = GAP_LD;
        end
      end
      S_CDGAP: begin
        if (zero) begin
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (rel) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // registered pin drive decoded from the current phase
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q   <= 1'b1;
      rd_q   <= 1'b1;
      wr_q   <= 1'b1;
      ad_q   <= 1'b0;
      oe_q   <= 1'b0;
      out_q  <= '0;
      esc_q  <= 1'b0;
      mem_q  <= 1'b0;
      last_q <= 1'b0;
      dm_q   <= '0;
    end else begin
      cs_q   <= 1'b1;
      rd_q   <= 1'b1;
      wr_q   <= 1'b1;
      ad_q   <= 1'b0;
      oe_q   <= 1'b0;
      last_q <= 1'b0;
      esc_q  <= (state_q == S_DONE) && (op_q == OP_WR) && bus.actesc;
      mem_q  <= (state_q == S_DONE) && (op_q == OP_RD) && bus.actlec;
      if (last_q) begin
        dm_q <= bus.ad_in;
      end
      unique case (state_q)
        S_ADDR: begin
          cs_q  <= 1'b0;
          wr_q  <= 1'b0;
          ad_q  <= 1'b1;
          oe_q  <= 1'b1;
          out_q <= addr_q;
        end
        S_AGAP: begin
          oe_q <= 1'b1;
        end
        S_DATA: begin
          cs_q <= 1'b0;
          if (op_q == OP_WR) begin
            wr_q  <= 1'b0;
            oe_q  <= 1'b1;
            out_q <= data_q;
          end else begin
            rd_q   <= 1'b0;
            last_q <= zero;
          end
        end
        S_DGAP: begin
          oe_q <= (op_q == OP_WR);
        end
`ifdef RTC_TRANSFER_CMD_EN
        S_CADDR: begin
          cs_q  <= 1'b0;
          wr_q  <= 1'b0;
          ad_q  <= 1'b1;
          oe_q  <= 1'b1;
          out_q <= CMD_ADDR;
        end
        S_CAGAP: begin
          oe_q <= 1'b1;
        end
        S_CDATA: begin
          cs_q  <= 1'b0;
          wr_q  <= 1'b0;
          oe_q  <= 1'b1;
          out_q <= CMD_ADDR;
        end
        S_CDGAP: begin
          oe_q <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.esclisto     = esc_q;
  assign bus.memorialisto = mem_q;
  assign bus.datomem      = dm_q;
  assign bus.ad_out       = out_q;
  assign bus.ad_oe        = oe_q;
  assign bus.cs_n         = cs_q;
  assign bus.rd_n         = rd_q;
  assign bus.wr_n         = wr_q;
  assign bus.a_d          = ad_q;

endmodule

// File: tb/tb_rtc_bus_driver.sv
// tb_rtc_bus_driver: two DUTs (default and 1/1 timing) against a cycle model.
// Model derives pin values from phase arithmetic on the cycle number.
module tb_rtc_bus_driver;

  localparam int P0 = 8;
  localparam int G0 = 4;
  localparam int P1 = 1;
  localparam int G1 = 1;
  localparam logic [7:0] CMD = 8'hF1;
`ifdef RTC_TRANSFER_CMD_EN
  localparam bit CMD_EN = 1'b1;
`else
  localparam bit CMD_EN = 1'b0;
`endif

  typedef struct packed {
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;
    logic       ad_oe;
    logic [7:0] ad_out;
  } pins_t;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  logic [7:0] dm0 = 8'h00;
  logic [7:0] dm1 = 8'h00;

  rtc_bus_driver_if b0 ();
  rtc_bus_driver_if b1 ();

  rtc_bus_driver #(.T_PULSE(P0), .T_GAP(G0), .CMD_ADDR(CMD)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  rtc_bus_driver #(.T_PULSE(P1), .T_GAP(G1), .CMD_ADDR(CMD)) u_fast (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  pins_t a0, a1;
  assign a0 = {b0.cs_n, b0.rd_n, b0.wr_n, b0.a_d, b0.ad_oe, b0.ad_out};
  assign a1 = {b1.cs_n, b1.rd_n, b1.wr_n, b1.a_d, b1.ad_oe, b1.ad_out};

  always #5 clk = ~clk;

  function automatic int total(input bit wr, input int p, input int g);
    return 2 * (p + g) * ((wr && CMD_EN) ? 2 : 1);
  endfunction

  function automatic pins_t model(input int n, input bit wr,
                                  input logic [7:0] a, input logic [7:0] d,
                                  input int p, input int g);
    pins_t e;
    int k, seg, w, r;
    e.cs_n = 1'b1; e.rd_n = 1'b1; e.wr_n = 1'b1;
    e.a_d = 1'b0; e.ad_oe = 1'b0; e.ad_out = 8'h00;
    if (n < 1 || (n - 1) >= total(wr, p, g)) return e;
    seg = p + g;
    k = n - 1;
    w = k / (2 * seg);
    r = k % (2 * seg);
    if (r < p) begin
      e.cs_n = 1'b0; e.wr_n = 1'b0; e.a_d = 1'b1; e.ad_oe = 1'b1;
      e.ad_out = (w == 0) ? a : CMD;
    end else if (r < seg) begin
      e.ad_oe = 1'b1;
      e.ad_out = (w == 0) ? a : CMD;
    end else if (r < seg + p) begin
      e.cs_n = 1'b0;
      if (wr) begin
        e.wr_n = 1'b0; e.ad_oe = 1'b1;
        e.ad_out = (w == 0) ? d : CMD;
      end else begin
        e.rd_n = 1'b0;
      end
    end else if (wr) begin
      e.ad_oe = 1'b1;
      e.ad_out = (w == 0) ? d : CMD;
    end
    return e;
  endfunction

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chkp(input string tag, input pins_t got, input pins_t exp);
    if (!exp.ad_oe) begin
      got.ad_out = 8'h00;
      exp.ad_out = 8'h00;
    end
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic txn(input bit w, input bit r, input logic [7:0] a,
                     input logic [7:0] d, input logic [7:0] v0, input int rst_at);
    bit wr;
    int t0, t1, dl0, dl1, h;
    logic [7:0] v1;
    wr = w;
    t0 = total(wr, P0, G0);
    t1 = total(wr, P1, G1);
    dl0 = 2 * P0 + G0;
    dl1 = 2 * P1 + G1;
    v1 = v0 ^ 8'h5A;
    @(posedge clk); #1;
    b0.actesc = w; b0.actlec = r; b0.dir = a; b0.dato = d; b0.ad_in = ~v0;
    b1.actesc = w; b1.actlec = r; b1.dir = a; b1.dato = d; b1.ad_in = ~v1;
    @(posedge clk); #1;
    chkp("c0_pins", a0, model(0, wr, a, d, P0, G0));
    chk1("c0_flag", b0.esclisto | b0.memorialisto, 1'b0);
    for (int n = 1; n <= t0 + 1; n++) begin
      @(posedge clk); #1;
      if (rst_at > 0 && n == rst_at + 1) begin
        chkp($sformatf("rst_pins_%0d", n), a0, model(0, wr, a, d, P0, G0));
        chkp($sformatf("rst_fpins_%0d", n), a1, model(0, wr, a, d, P1, G1));
        chk1("rst_esc", b0.esclisto, 1'b0);
        chk1("rst_fesc", b1.esclisto, 1'b0);
        chk8("rst_dm", b0.datomem, 8'h00);
        chk8("rst_fdm", b1.datomem, 8'h00);
        dm0 = 8'h00; dm1 = 8'h00;
        reset = 1'b0;
        b0.actesc = 1'b0; b0.actlec = 1'b0;
        b1.actesc = 1'b0; b1.actlec = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(posedge clk); #1;
          chkp($sformatf("post_rst_idle_%0d", i), a0, model(0, wr, a, d, P0, G0));
          chk1($sformatf("post_rst_noesc_%0d", i), b0.esclisto, 1'b0);
        end
        return;
      end
      chkp($sformatf("pins_c%0d", n), a0, model(n, wr, a, d, P0, G0));
      chkp($sformatf("fpins_c%0d", n), a1, model(n, wr, a, d, P1, G1));
      chk1($sformatf("esc_c%0d", n), b0.esclisto, wr && n > t0);
      chk1($sformatf("mem_c%0d", n), b0.memorialisto, !wr && n > t0);
      chk1($sformatf("fesc_c%0d", n), b1.esclisto, wr && n > t1);
      chk1($sformatf("fmem_c%0d", n), b1.memorialisto, !wr && n > t1);
      chk8($sformatf("dm_c%0d", n), b0.datomem, (!wr && n > dl0) ? v0 : dm0);
      chk8($sformatf("fdm_c%0d", n), b1.datomem, (!wr && n > dl1) ? v1 : dm1);
      b0.dir = 8'($urandom); b0.dato = 8'($urandom);
      b1.dir = b0.dir; b1.dato = b0.dato;
      b0.ad_in = (n == dl0) ? v0 : ~v0;
      b1.ad_in = (n == dl1) ? v1 : ~v1;
      if (rst_at == n) reset = 1'b1;
    end
    h = $urandom_range(0, 3);
    for (int i = 0; i < h; i++) begin
      @(posedge clk); #1;
      chk1("hold_esc", b0.esclisto, wr);
      chk1("hold_mem", b0.memorialisto, !wr);
    end
    b0.actesc = 1'b0; b0.actlec = 1'b0;
    b1.actesc = 1'b0; b1.actlec = 1'b0;
    @(posedge clk); #1;
    chk1("drop_esc", b0.esclisto, 1'b0);
    chk1("drop_mem", b0.memorialisto, 1'b0);
    chk1("drop_fesc", b1.esclisto, 1'b0);
    chk1("drop_fmem", b1.memorialisto, 1'b0);
    chkp("drop_pins", a0, model(0, wr, a, d, P0, G0));
    if (!wr) begin
      dm0 = v0;
      dm1 = v1;
    end
    chk8("drop_dm", b0.datomem, dm0);
    chk8("drop_fdm", b1.datomem, dm1);
  endtask

  initial begin
    bit rw;
    reset = 1'b1;
    b0.actesc = 1'b0; b0.actlec = 1'b0; b0.dir = '0; b0.dato = '0; b0.ad_in = '0;
    b1.actesc = 1'b0; b1.actlec = 1'b0; b1.dir = '0; b1.dato = '0; b1.ad_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_cs_n", b0.cs_n, 1'b1);
    chk1("rst_rd_n", b0.rd_n, 1'b1);
    chk1("rst_wr_n", b0.wr_n, 1'b1);
    chk1("rst_a_d", b0.a_d, 1'b0);
    chk1("rst_ad_oe", b0.ad_oe, 1'b0);
    chk8("rst_ad_out", b0.ad_out, 8'h00);
    chk1("rst_esclisto", b0.esclisto, 1'b0);
    chk1("rst_memorialisto", b0.memorialisto, 1'b0);
    chk8("rst_datomem", b0.datomem, 8'h00);
    reset = 1'b0;

    txn(1'b1, 1'b0, 8'h22, 8'h59, 8'h00, 0);
    txn(1'b0, 1'b1, 8'h41, 8'h00, 8'h17, 0);
    txn(1'b1, 1'b0, 8'h23, 8'h6C, 8'h00, 0);
    txn(1'b1, 1'b1, 8'h35, 8'hA7, 8'h00, 0);
    txn(1'b1, 1'b0, 8'h10, 8'h3C, 8'h00, 12);
    txn(1'b0, 1'b1, 8'h07, 8'h00, 8'hC3, 0);

    for (int i = 0; i < 6; i++) begin
      rw = 1'($urandom);
      txn(rw, !rw || 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
